lock_key_sequencer: RTL and testbench
=====================================

// Module: lock_key_sequencer
// PURPOSE
//  Drives the time-varying key bus of a counter-epoch key-locked FSM.
//  Holds one key per epoch in loadable slots and owns the target's reset.
//  Keeps an internal epoch counter in lockstep with the target's counter, so the
//  target always sees the key for its current epoch. Sits between the key-config
//  interface and the locked design's keyinput0..17 pins.
// PARAMETERS
//  KEY_W      18  key width (bit i drives target keyinput<i>)
//  N_EPOCH    6   number of key epochs / slots
//  EPOCH_LEN  5   cycles per epoch
//  CNT_W      6   counter width; must hold N_EPOCH*EPOCH_LEN-1
//  IDX_W      3   slot index width; must be >= clog2(N_EPOCH)
// PORTS
//  clk        in   1      clock; all state updates on negedge clk (target timing)
//  rst        in   1      asynchronous, active-high reset
//  cfg_we     in   1      slot write strobe (one write per cycle)
//  cfg_addr   in   IDX_W  slot index
//  cfg_data   in   KEY_W  key value
//  start      in   1      request RUN (level sampled at clock edge)
//  stop       in   1      request return to IDLE
//  tgt_rst    out  1      reset to locked design, active-high, registered
//  key_out    out  KEY_W  key bus to target, registered
//  epoch_idx  out  IDX_W  current epoch (cnt / EPOCH_LEN)
//  running    out  1      high in RUN
//  cfg_err    out  1      one-cycle error pulse
// BEHAVIOUR
//  Reset: state=IDLE, tgt_rst=1, key_out=0, cnt=0, epoch_idx=0, running=0,
//   cfg_err=0, all slots=0, slot_valid=0.
//  IDLE: tgt_rst=1, key_out=0.
//   - cfg_we with cfg_addr<N_EPOCH: write slot, set slot_valid[addr].
//   - cfg_we with addr>=N_EPOCH: no write, cfg_err pulse.
//   - start with all slot_valid set -> ARM.
//   - start with any slot invalid: cfg_err pulse, stay IDLE.
//  ARM (1 cycle): tgt_rst=1, cnt=0, key_out<=slot[0] -> RUN.
//  RUN:
//   - tgt_rst=0, running=1.
//   - cnt wraps N_EPOCH*EPOCH_LEN-1 -> 0.
//   - key_out <= slot[(cnt_next)/EPOCH_LEN], so the key for count c is stable
//     throughout the cycle in which the target counter equals c.
//   - Epoch boundary at c=EPOCH_LEN*k: key changes on the same edge the counter
//     enters epoch k. 0 extra cycles latency.
//   - cfg_we in RUN: ignored, cfg_err pulse; slots unchanged.
//   - stop -> IDLE on next edge: tgt_rst=1, key_out=0, cnt=0.
//  start & stop on the same edge: stop wins (IDLE, or stay IDLE).
//  start while already in RUN: ignored, no error.
//  rst mid-RUN: immediate return to reset values; slots cleared, must reload.
//  epoch_idx tracks cnt in every state; 0 outside RUN.
// STRUCTURE
//  Package lock_key_pkg:
//   - KEY_W, N_EPOCH, EPOCH_LEN, CNT_W, IDX_W
//   - state encoding IDLE/ARM/RUN
//   - function epoch_of(cnt)
//  Sub-module epoch_counter:
//   - negedge wrap counter
//   - ports clk, rst, clr, en
//   - outputs cnt, cnt_next, epoch
//   - same instance type reusable in other locked benchmarks
//  Top: slot regfile (N_EPOCH x KEY_W + valid bits), 3-state FSM, key_out register.
// TESTING
//  1. Load slots 0..5 = 18'h2E9C1,1B1D8,3C2CB,209EC,0AC2D,017FD; start
//     -> tgt_rst falls 2 edges later; key_out=2E9C1 for counts 0-4,
//     1B1D8 for 5-9, ... 017FD for 25-29; wrap back to 2E9C1 at count 30.
//  2. Load only slots 0..4; start -> cfg_err=1 for one cycle,
//     state IDLE, tgt_rst=1, key_out=0.
//  3. In RUN at count 12, cfg_we addr 2 data 0 -> cfg_err pulse;
//     key_out stays 3C2CB through count 14.
//  4. cfg_we addr 7 in IDLE -> cfg_err pulse; slot_valid unchanged;
//     subsequent start rejected if slots incomplete.
//  5. start=stop=1 in IDLE -> stays IDLE. Same in RUN at count 17 -> IDLE next
//     edge, key_out=0, tgt_rst=1; restart -> key_out=slot0 at count 0.
//  6. Assert rst at count 22 -> all outputs at reset values asynchronously;
//     start without reload -> cfg_err.

Source files
------------

// File: rtl/lock_key_sequencer_pkg.sv
// Shared parameters, FSM encoding and count-to-epoch mapping for the lock key sequencer.
package lock_key_pkg;

  localparam int unsigned KEY_W     = 18;
  localparam int unsigned N_EPOCH   = 6;
  localparam int unsigned EPOCH_LEN = 5;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CNT_MAX   = N_EPOCH * EPOCH_LEN - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] epoch_of(input logic [CNT_W-1:0] cnt);
    return IDX_W'(cnt / CNT_W'(EPOCH_LEN));
  endfunction

endpackage

// File: rtl/lock_key_sequencer_if.sv
// Key-config / control / key-bus bundle between the host side and the sequencer.
interface lock_key_sequencer_if;
  import lock_key_pkg::*;

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [KEY_W-1:0] cfg_data;
  logic             start;
  logic             stop;
  logic             tgt_rst;
  logic [KEY_W-1:0] key_out;
  logic [IDX_W-1:0] epoch_idx;
  logic             running;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, stop,
    input  tgt_rst, key_out, epoch_idx, running, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, stop,
    output tgt_rst, key_out, epoch_idx, running, cfg_err
  );

endinterface

// File: rtl/lock_key_sequencer_epoch_counter.sv
// Negedge wrap counter mirroring the locked target's internal counter; reusable across benchmarks.
module epoch_counter
  import lock_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic [IDX_W-1:0] epoch
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] epoch_q;

  assign cnt_next = (cnt_q == CNT_W'(CNT_MAX)) ? '0 : cnt_q + CNT_W'(1);
  assign cnt_d    = clr ? '0 : (en ? cnt_next : cnt_q);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      epoch_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      epoch_q <= epoch_of(cnt_d);
    end
  end

  assign cnt   = cnt_q;
  assign epoch = epoch_q;

endmodule

// File: rtl/lock_key_sequencer.sv
// Loads per-epoch keys, owns the target reset and presents the current epoch's key in lockstep.
module lock_key_sequencer
  import lock_key_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  lock_key_sequencer_if.slave bus
);

  state_e             state_q;
  logic               tgt_rst_q;
  logic [KEY_W-1:0]   key_q;
  logic               running_q;
  logic               cfg_err_q;
  logic [KEY_W-1:0]   slot_q [N_EPOCH];
  logic [N_EPOCH-1:0] slot_valid_q;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [IDX_W-1:0]   epoch;
  logic               cnt_clr;
  logic               cnt_en;

  // Counter only advances in RUN; held at zero otherwise and on the stop edge.
  assign cnt_en  = (state_q == ST_RUN);
  assign cnt_clr = (state_q != ST_RUN) || bus.stop;

  epoch_counter u_epoch_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt      (cnt),
    .cnt_next (cnt_next),
    .epoch    (epoch)
  );

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tgt_rst_q    <= 1'b1;
      key_q        <= '0;
      running_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      slot_valid_q <= '0;
      for (int unsigned i = 0; i < N_EPOCH; i++) slot_q[i] <= '0;
    end else begin
      cfg_err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          tgt_rst_q <= 1'b1;
          running_q <= 1'b0;
          key_q     <= '0;
          if (bus.cfg_we) begin
            if (bus.cfg_addr < IDX_W'(N_EPOCH)) begin
              slot_q[bus.cfg_addr]       <= bus.cfg_data;
              slot_valid_q[bus.cfg_addr] <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          if (bus.start && !bus.stop) begin
            if (&slot_valid_q) begin
              state_q <= ST_ARM;
              key_q   <= slot_q[0];
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (bus.cfg_we) cfg_err_q <= 1'b1;
          if (bus.stop) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
          end else begin
            // Counter is held at zero here, so this selects slot 0 for the first RUN cycle.
            state_q   <= ST_RUN;
            tgt_rst_q <= 1'b0;
            running_q <= 1'b1;
            key_q     <= slot_q[epoch_of(cnt)];
          end
        end
        ST_RUN: begin
          if (bus.cfg_we) cfg_err_q <= 1'b1;
          if (bus.stop) begin
            state_q   <= ST_IDLE;
            tgt_rst_q <= 1'b1;
            running_q <= 1'b0;
            key_q     <= '0;
          end else begin
            key_q <= slot_q[epoch_of(cnt_next)];
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          tgt_rst_q <= 1'b1;
          running_q <= 1'b0;
          key_q     <= '0;
        end
      endcase
    end
  end

  assign bus.tgt_rst   = tgt_rst_q;
  assign bus.key_out   = key_q;
  assign bus.epoch_idx = epoch;
  assign bus.running   = running_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Self-checking bench: fixed vector table, directed epoch/corner sequences and a randomized run.
module tb_lock_key_sequencer;

  localparam int NE   = 6;
  localparam int ELEN = 5;
  localparam int PER  = NE * ELEN;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lock_key_sequencer_if bus ();

  lock_key_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  logic [17:0] K [NE];

  typedef struct {
    bit        we;
    bit [2:0]  addr;
    bit [17:0] data;
    bit        st;
    bit        sp;
    bit        e_tgt;
    bit [17:0] e_key;
    bit [2:0]  e_ep;
    bit        e_run;
    bit        e_err;
  } vec_t;

  vec_t vecs [14];

  // Behavioural model: phase 0 idle, 1 arming, 2 running; count = elapsed RUN cycles mod PER.
  int        m_phase;
  int        m_t;
  bit [17:0] m_slot [NE];
  bit        m_valid [NE];
  bit        m_err;

  function automatic vec_t mk(bit we, bit [2:0] addr, bit [17:0] data, bit st, bit sp,
                              bit e_tgt, bit [17:0] e_key, bit [2:0] e_ep, bit e_run, bit e_err);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.st = st; v.sp = sp;
    v.e_tgt = e_tgt; v.e_key = e_key; v.e_ep = e_ep; v.e_run = e_run; v.e_err = e_err;
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_err   = 0;
    for (int i = 0; i < NE; i++) begin
      m_slot[i]  = '0;
      m_valid[i] = 0;
    end
  endtask

  task automatic model_step(bit we, bit [2:0] addr, bit [17:0] data, bit st, bit sp);
    bit all_v;
    m_err = 0;
    all_v = 1;
    for (int i = 0; i < NE; i++) if (!m_valid[i]) all_v = 0;
    if (m_phase == 0) begin
      if (we) begin
        if (int'(addr) < NE) begin
          m_slot[addr]  = data;
          m_valid[addr] = 1;
        end else m_err = 1;
      end
      if (st && !sp) begin
        if (all_v) m_phase = 1;
        else m_err = 1;
      end
    end else if (m_phase == 1) begin
      if (we) m_err = 1;
      m_phase = sp ? 0 : 2;
      m_t     = 0;
    end else begin
      if (we) m_err = 1;
      if (sp) m_phase = 0;
      else m_t++;
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(string tag, bit tgt, bit [17:0] key, bit [2:0] ep, bit run, bit err);
    chk({tag, ".tgt_rst"},   32'(bus.tgt_rst),   32'(tgt));
    chk({tag, ".key_out"},   32'(bus.key_out),   32'(key));
    chk({tag, ".epoch_idx"}, 32'(bus.epoch_idx), 32'(ep));
    chk({tag, ".running"},   32'(bus.running),   32'(run));
    chk({tag, ".cfg_err"},   32'(bus.cfg_err),   32'(err));
  endtask

  task automatic chk_model(string tag);
    int c;
    c = m_t % PER;
    case (m_phase)
      0:       chk_out(tag, 1, '0, '0, 0, m_err);
      1:       chk_out(tag, 1, m_slot[0], '0, 0, m_err);
      default: chk_out(tag, 0, m_slot[c / ELEN], 3'(c / ELEN), 1, m_err);
    endcase
  endtask

  // Drive one cycle of inputs; the DUT updates on the intervening negedge, outputs read at posedge.
  task automatic tick(bit we, bit [2:0] addr, bit [17:0] data, bit st, bit sp);
    bus.cfg_we   = we;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    bus.start    = st;
    bus.stop     = sp;
    model_step(we, addr, data, st, sp);
    @(posedge clk);
  endtask

  task automatic run_to(int c);
    int n;
    n = 0;
    while (!(m_phase == 2 && (m_t % PER) == c) && n < 100) begin
      tick(0, 0, 0, 0, 0);
      chk_model("run_to");
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL run_to: count %0d not reached, got phase %0d expected 2", c, m_phase);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    K[0] = 18'h2E9C1; K[1] = 18'h1B1D8; K[2] = 18'h3C2CB;
    K[3] = 18'h209EC; K[4] = 18'h0AC2D; K[5] = 18'h017FD;

    vecs[0]  = mk(1, 0, K[0], 0, 0,  1, '0,   0, 0, 0);
    vecs[1]  = mk(1, 1, K[1], 0, 0,  1, '0,   0, 0, 0);
    vecs[2]  = mk(1, 2, K[2], 0, 0,  1, '0,   0, 0, 0);
    vecs[3]  = mk(1, 3, K[3], 0, 0,  1, '0,   0, 0, 0);
    vecs[4]  = mk(1, 4, K[4], 0, 0,  1, '0,   0, 0, 0);
    vecs[5]  = mk(0, 0, '0,   1, 0,  1, '0,   0, 0, 1);
    vecs[6]  = mk(0, 0, '0,   0, 0,  1, '0,   0, 0, 0);
    vecs[7]  = mk(1, 7, 18'h3FFFF, 0, 0, 1, '0, 0, 0, 1);
    vecs[8]  = mk(0, 0, '0,   1, 0,  1, '0,   0, 0, 1);
    vecs[9]  = mk(1, 5, K[5], 0, 0,  1, '0,   0, 0, 0);
    vecs[10] = mk(0, 0, '0,   1, 0,  1, K[0], 0, 0, 0);
    vecs[11] = mk(0, 0, '0,   0, 0,  0, K[0], 0, 1, 0);
    vecs[12] = mk(0, 0, '0,   1, 1,  1, '0,   0, 0, 0);
    vecs[13] = mk(0, 0, '0,   1, 1,  1, '0,   0, 0, 0);

    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.start = 0; bus.stop = 0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 chk_out("reset", 1, '0, '0, 0, 0);
    #6 rst = 1'b0;
    @(posedge clk);

    // Fixed vectors: partial load rejected, bad address, full load, start/stop priority.
    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].st, vecs[i].sp);
      chk_out($sformatf("vec%0d", i), vecs[i].e_tgt, vecs[i].e_key, vecs[i].e_ep,
              vecs[i].e_run, vecs[i].e_err);
    end

    // Full epoch walk including wrap.
    tick(0, 0, 0, 1, 0);
    chk_out("arm", 1, K[0], 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk_out("run_c0", 0, K[0], 0, 1, 0);
    for (int c = 1; c <= PER; c++) begin
      tick(0, 0, 0, 0, 0);
      chk_model("walk");
      if (c == 4)  chk("walk_c4_key",  32'(bus.key_out), 32'(K[0]));
      if (c == 5)  chk("walk_c5_key",  32'(bus.key_out), 32'(K[1]));
      if (c == 29) chk("walk_c29_key", 32'(bus.key_out), 32'(K[5]));
      if (c == PER) begin
        chk("wrap_key",   32'(bus.key_out),   32'(K[0]));
        chk("wrap_epoch", 32'(bus.epoch_idx), 32'(0));
      end
    end

    // Write attempt during RUN is rejected without touching the slot.
    run_to(12);
    tick(1, 2, 18'h0, 0, 0);
    chk_out("run_we_c13", 0, K[2], 2, 1, 1);
    tick(0, 0, 0, 0, 0);
    chk_out("run_we_c14", 0, K[2], 2, 1, 0);
    run_to(12);
    chk("slot2_kept", 32'(bus.key_out), 32'(K[2]));

    // start+stop in RUN returns to IDLE; restart begins at slot 0.
    run_to(17);
    tick(0, 0, 0, 1, 1);
    chk_out("stop_c17", 1, '0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    chk_out("rearm", 1, K[0], 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk_out("restart_c0", 0, K[0], 0, 1, 0);

    // Asynchronous reset mid-RUN clears slots.
    run_to(22);
    rst = 1'b1;
    #1 chk_out("async_rst", 1, '0, 0, 0, 0);
    model_reset();
    #2 rst = 1'b0;
    tick(0, 0, 0, 1, 0);
    chk_out("start_after_rst", 1, '0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < NE; i++) begin
      tick(1, 3'(i), 18'($urandom), 0, 0);
      chk_model("rload");
    end
    for (int n = 0; n < 1500; n++) begin
      bit we, st, sp;
      we = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      tick(we, 3'($urandom_range(0, 7)), 18'($urandom), st, sp);
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
